// File: rtl/msg_sched_stream.sv
// Streaming SHA-256 / SHA-512 message-schedule engine: takes W0..W15 on a valid/ready
// input, expands W16..W(NUM_ROUNDS-1) from a rolling 16-word window, emits every W_t in order.
module msg_sched_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic [6:0]            w_round_out,
    output logic                  w_valid_out,
    input  logic                  w_ready_in,
    output logic                  done_out,
    output logic [1:0]            o_FSM_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        EXPAND = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [6:0] LAST_LOAD  = 7'd15;
    localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                   input int unsigned n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    // Only DATA_WIDTH 32 and 64 are legal; anything other than 64 selects the SHA-256 set.
    function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
        if (DATA_WIDTH == 64)
            return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
        else
            return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
        if (DATA_WIDTH == 64)
            return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
        else
            return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic [6:0]            round;
    logic [DATA_WIDTH-1:0] win [16];
    logic                  adv;
    logic                  load_en;
    logic                  done_set;
    logic [DATA_WIDTH-1:0] w_calc;
    logic [DATA_WIDTH-1:0] w_load;

    // win[15] is the newest word W(t-1), win[0] the oldest W(t-16).
    assign adv            = !w_valid_out || w_ready_in;
    assign w_calc         = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign w_load         = (state == LOAD) ? data_in : w_calc;
    assign data_ready_out = (state == LOAD) && adv;
    assign o_FSM_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start_in)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (data_valid_in && adv) begin
                    load_en = 1'b1;
                    if (round == LAST_LOAD)
                        state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (adv) begin
                    load_en = 1'b1;
                    if (round == LAST_ROUND)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                // The last word was loaded on the edge that entered DONE, so any
                // handshake seen here is the final one.
                if (w_valid_out && w_ready_in) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_in) begin
            state_nxt = IDLE;
            load_en   = 1'b0;
            done_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round       <= '0;
            w_valid_out <= 1'b0;
            done_out    <= 1'b0;
        end else begin
            done_out <= done_set;
            if (abort_in)
                round <= '0;
            else if (state == IDLE && start_in)
                round <= '0;
            else if (load_en)
                round <= round + 7'd1;

            if (abort_in)
                w_valid_out <= 1'b0;
            else if (load_en)
                w_valid_out <= 1'b1;
            else if (w_ready_in)
                w_valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_out       <= '0;
            w_round_out <= '0;
            for (int i = 0; i < 16; i++)
                win[i] <= '0;
        end else if (load_en) begin
            w_out       <= w_load;
            w_round_out <= round;
            for (int i = 0; i < 15; i++)
                win[i] <= win[i+1];
            win[15] <= w_load;
        end
    end

endmodule

// File: tb/tb_msg_sched_stream.sv
// Bench for msg_sched_stream: a SHA-256 and a SHA-512 instance, compared against a
// full-array schedule model, known-answer table and hand-written abort/reset sequences.
module tb_msg_sched_stream;

    localparam int N32 = 64;
    localparam int N64 = 80;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        a_rst_n, a_start, a_abort, a_dvalid, a_dready, a_wvalid, a_wready, a_done;
    logic [31:0] a_data, a_w;
    logic [6:0]  a_round;
    logic [1:0]  a_state;
    logic        b_rst_n, b_start, b_abort, b_dvalid, b_dready, b_wvalid, b_wready, b_done;
    logic [63:0] b_data, b_w;
    logic [6:0]  b_round;
    logic [1:0]  b_state;

    msg_sched_stream #(.DATA_WIDTH(32), .NUM_ROUNDS(N32)) dut32 (
        .clk(clk), .rst_n(a_rst_n), .start_in(a_start), .abort_in(a_abort),
        .data_in(a_data), .data_valid_in(a_dvalid), .data_ready_out(a_dready),
        .w_out(a_w), .w_round_out(a_round), .w_valid_out(a_wvalid), .w_ready_in(a_wready),
        .done_out(a_done), .o_FSM_state(a_state)
    );

    msg_sched_stream #(.DATA_WIDTH(64), .NUM_ROUNDS(N64)) dut64 (
        .clk(clk), .rst_n(b_rst_n), .start_in(b_start), .abort_in(b_abort),
        .data_in(b_data), .data_valid_in(b_dvalid), .data_ready_out(b_dready),
        .w_out(b_w), .w_round_out(b_round), .w_valid_out(b_wvalid), .w_ready_in(b_wready),
        .done_out(b_done), .o_FSM_state(b_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: whole schedule as a flat array, straight from the recurrence.
    logic [63:0] blk   [16];
    logic [63:0] exp_w [128];

    function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n, input bit s64);
        logic [31:0] lo;
        if (s64)
            return (x >> n) | (x << (64 - n));
        lo = x[31:0];
        return {32'h0, (lo >> n) | (lo << (32 - n))};
    endfunction

    function automatic logic [63:0] sig0_m(input logic [63:0] x, input bit s64);
        if (s64) return rotr_m(x, 1, 1'b1) ^ rotr_m(x, 8, 1'b1) ^ (x >> 7);
        return rotr_m(x, 7, 1'b0) ^ rotr_m(x, 18, 1'b0) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] sig1_m(input logic [63:0] x, input bit s64);
        if (s64) return rotr_m(x, 19, 1'b1) ^ rotr_m(x, 61, 1'b1) ^ (x >> 6);
        return rotr_m(x, 17, 1'b0) ^ rotr_m(x, 19, 1'b0) ^ (x >> 10);
    endfunction

    task automatic build_model(input bit s64);
        logic [63:0] mask;
        int n;
        mask = s64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        n = s64 ? N64 : N32;
        for (int t = 0; t < 128; t++) exp_w[t] = 64'h0;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t] & mask;
        for (int t = 16; t < n; t++)
            exp_w[t] = (sig1_m(exp_w[t-2], s64) + exp_w[t-7] + sig0_m(exp_w[t-15], s64)
                        + exp_w[t-16]) & mask;
    endtask

    typedef struct packed {
        logic [63:0] w;
        logic [6:0]  r;
    } cap_t;

    cap_t cap_a[$];
    cap_t cap_b[$];
    cap_t k32 [128];
    cap_t k64 [128];

    logic        prev_stall [2];
    logic        prev_abort [2];
    logic        prev_done  [2];
    logic [63:0] prev_w     [2];
    logic [6:0]  prev_r     [2];
    int          done_cnt   [2];

    task automatic mon(input int s);
        logic rst, v, r, dr, dn, ab;
        logic [63:0] w;
        logic [6:0]  rd;
        logic [1:0]  st;
        if (s == 1) begin
            rst = b_rst_n; v = b_wvalid; r = b_wready; dr = b_dready; dn = b_done;
            ab = b_abort; w = b_w; rd = b_round; st = b_state;
        end else begin
            rst = a_rst_n; v = a_wvalid; r = a_wready; dr = a_dready; dn = a_done;
            ab = a_abort; w = {32'h0, a_w}; rd = a_round; st = a_state;
        end
        if (!rst) begin
            prev_stall[s] = 1'b0;
            prev_abort[s] = 1'b0;
            prev_done[s]  = 1'b0;
            return;
        end
        if (prev_stall[s] && !prev_abort[s]) begin
            chk($sformatf("mon%0d_hold_valid", s), 64'(v), 64'd1);
            chk($sformatf("mon%0d_hold_w", s), w, prev_w[s]);
            chk($sformatf("mon%0d_hold_round", s), 64'(rd), 64'(prev_r[s]));
        end
        chk($sformatf("mon%0d_ready_rule", s), 64'(dr), 64'(st == 2'b01 && (!v || r)));
        if (dn) begin
            done_cnt[s]++;
            chk($sformatf("mon%0d_done_single", s), 64'(prev_done[s]), 64'd0);
            chk($sformatf("mon%0d_done_idle", s), 64'(st), 64'd0);
        end
        if (v && r) begin
            if (s == 1) cap_b.push_back('{w: w, r: rd});
            else        cap_a.push_back('{w: w, r: rd});
        end
        prev_stall[s] = v && !r;
        prev_w[s]     = w;
        prev_r[s]     = rd;
        prev_abort[s] = ab;
        prev_done[s]  = dn;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    int stall_a = 0;
    int stall_b = 0;
    initial begin
        a_wready = 1'b1;
        b_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_wready = ($urandom_range(0, 99) >= stall_a);
            b_wready = ($urandom_range(0, 99) >= stall_b);
        end
    end

    task automatic set_start(input bit s64, input logic v);
        if (s64) b_start = v;
        else     a_start = v;
    endtask

    task automatic set_data(input bit s64, input logic dv, input logic [63:0] d);
        if (s64) begin b_dvalid = dv; b_data = d; end
        else     begin a_dvalid = dv; a_data = d[31:0]; end
    endtask

    task automatic feed(input bit s64, input int gap_pct, input bit hold_start);
        int guard;
        set_start(s64, 1'b1);
        @(posedge clk); #1;
        if (!hold_start) set_start(s64, 1'b0);
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                set_data(s64, 1'b0, 64'h0);
                @(posedge clk); #1;
            end
            set_data(s64, 1'b1, blk[i]);
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!(s64 ? b_dready : a_dready) && guard < 500);
            chk($sformatf("feed_ready_w%0d", i), 64'(s64 ? b_dready : a_dready), 64'd1);
            if (!(s64 ? b_dready : a_dready)) begin
                set_data(s64, 1'b0, 64'h0);
                set_start(s64, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        set_data(s64, 1'b0, 64'h0);
        set_start(s64, 1'b0);
    endtask

    task automatic wait_done(input bit s64, input string tag);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(s64 ? b_done : a_done) && guard < 5000);
        chk({tag, "_done"}, 64'(s64 ? b_done : a_done), 64'd1);
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(s64 ? b_done : a_done), 64'd0);
        chk({tag, "_idle_after"}, 64'(s64 ? b_state : a_state), 64'd0);
    endtask

    task automatic compare(input bit s64, input string tag);
        int n, sz;
        cap_t c;
        n  = s64 ? N64 : N32;
        sz = s64 ? cap_b.size() : cap_a.size();
        chk({tag, "_count"}, 64'(sz), 64'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            c = s64 ? cap_b[i] : cap_a[i];
            chk($sformatf("%s_w%0d", tag, i), c.w, exp_w[i]);
            chk($sformatf("%s_r%0d", tag, i), 64'(c.r), 64'(i));
        end
    endtask

    task automatic load_abc(input bit s64);
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = s64 ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
        blk[15] = 64'h18;
    endtask

    task automatic run_block(input bit s64, input int gap_pct, input bit hold_start,
                             input string tag);
        build_model(s64);
        if (s64) cap_b.delete();
        else     cap_a.delete();
        done_cnt[s64 ? 1 : 0] = 0;
        feed(s64, gap_pct, hold_start);
        wait_done(s64, tag);
        compare(s64, tag);
        chk({tag, "_done_count"}, 64'(done_cnt[s64 ? 1 : 0]), 64'd1);
    endtask

    typedef struct {
        bit          s64;
        int          t;
        logic [63:0] w;
    } kat_t;
    kat_t kat [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        cap_t c;
        kat[0] = '{1'b0, 0,  64'h0000_0000_6162_6380};
        kat[1] = '{1'b0, 15, 64'h0000_0000_0000_0018};
        kat[2] = '{1'b0, 16, 64'h0000_0000_6162_6380};
        kat[3] = '{1'b0, 17, 64'h0000_0000_000F_0000};
        kat[4] = '{1'b1, 0,  64'h6162_6380_0000_0000};
        kat[5] = '{1'b1, 15, 64'h0000_0000_0000_0018};
        kat[6] = '{1'b1, 16, 64'h6162_6380_0000_0000};
        kat[7] = '{1'b1, 17, 64'h0003_0000_0000_00C0};
        for (int i = 0; i < 128; i++) begin
            k32[i] = '0;
            k64[i] = '0;
        end

        a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_dvalid = 1'b0; a_data = 32'h0;
        b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_dvalid = 1'b0; b_data = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_a_state", 64'(a_state), 64'd0);
        chk("rst_a_valid", 64'(a_wvalid), 64'd0);
        chk("rst_a_w", 64'(a_w), 64'd0);
        chk("rst_a_round", 64'(a_round), 64'd0);
        chk("rst_a_done", 64'(a_done), 64'd0);
        chk("rst_a_dready", 64'(a_dready), 64'd0);
        chk("rst_b_state", 64'(b_state), 64'd0);
        chk("rst_b_valid", 64'(b_wvalid), 64'd0);
        chk("rst_b_w", b_w, 64'd0);
        chk("rst_b_round", 64'(b_round), 64'd0);
        chk("rst_b_done", 64'(b_done), 64'd0);
        chk("rst_b_dready", 64'(b_dready), 64'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;

        // SHA-256 and SHA-512 "abc" with the consumer always ready
        load_abc(1'b0);
        run_block(1'b0, 0, 1'b0, "t1");
        for (int i = 0; i < cap_a.size() && i < 128; i++) k32[i] = cap_a[i];
        load_abc(1'b1);
        run_block(1'b1, 0, 1'b0, "t2");
        for (int i = 0; i < cap_b.size() && i < 128; i++) k64[i] = cap_b[i];

        for (int i = 0; i < 8; i++) begin
            c = kat[i].s64 ? k64[kat[i].t] : k32[kat[i].t];
            chk($sformatf("kat%0d_w", i), c.w, kat[i].w);
            chk($sformatf("kat%0d_r", i), 64'(c.r), 64'(kat[i].t));
        end

        // Output backpressure, then input gaps
        load_abc(1'b0);
        stall_a = 50;
        run_block(1'b0, 0, 1'b0, "t3");
        stall_a = 30;
        run_block(1'b0, 60, 1'b0, "t4");
        stall_a = 0;

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = {32'h0, $urandom()};
            stall_a = $urandom_range(0, 70);
            run_block(1'b0, $urandom_range(0, 50), 1'b0, $sformatf("rnd32_%0d", r));
        end
        stall_a = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = {$urandom(), $urandom()};
            stall_b = $urandom_range(0, 60);
            run_block(1'b1, $urandom_range(0, 40), 1'b0, $sformatf("rnd64_%0d", r));
        end
        stall_b = 0;

        // Abort while word 30 is on the output
        load_abc(1'b0);
        build_model(1'b0);
        cap_a.delete();
        done_cnt[0] = 0;
        feed(1'b0, 0, 1'b0);
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!(a_wvalid && a_round == 7'd30) && guard < 200);
        chk("t5_reach30", 64'(a_round), 64'd30);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        chk("t5_state", 64'(a_state), 64'd0);
        chk("t5_valid", 64'(a_wvalid), 64'd0);
        chk("t5_dready", 64'(a_dready), 64'd0);
        repeat (5) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt[0]), 64'd0);
        run_block(1'b0, 0, 1'b0, "t5");

        // Asynchronous reset mid-EXPAND, then start_in held high through LOAD
        build_model(1'b0);
        feed(1'b0, 0, 1'b0);
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!(a_state == 2'b10 && a_round >= 7'd20) && guard < 200);
        chk("t6_in_expand", 64'(a_state), 64'd2);
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("t6_state", 64'(a_state), 64'd0);
        chk("t6_valid", 64'(a_wvalid), 64'd0);
        chk("t6_w", 64'(a_w), 64'd0);
        chk("t6_round", 64'(a_round), 64'd0);
        chk("t6_done", 64'(a_done), 64'd0);
        chk("t6_dready", 64'(a_dready), 64'd0);
        @(posedge clk); #1;
        chk("t6_state_held", 64'(a_state), 64'd0);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(1'b0, 20, 1'b1, "t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
